// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_if
//  Description : Request/response handshake bundle between an issuing unit
//                (master) and the ALU operation sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [OP_W-1:0]  req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  // Issuing side: drives requests, consumes responses
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  // Sequencer side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Sequences one ALU operation per request handshake. Logic and
//                add/sub complete in one cycle; shifts and multiply iterate one
//                bit per cycle. Owns the architectural {Z,N,C,V} flags.
//                Optional macro ALU_SEQ_MUL_EN builds the 16-cycle shift-add
//                multiplier; without it opcode 8 is reported as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    seq_if,
  output logic [3:0]           flags_o,
  output logic                 busy_o
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_NOT = OP_W'(3);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  // Operand A shadow doubles as the shift working register
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [3:0]       flags_q, flags_d;

`ifdef ALU_SEQ_MUL_EN
  // Operand B shadow doubles as the multiplier, consumed LSB first
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_mul_hi;
`endif

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_is_single;
  logic             w_is_shift;
  logic [SH_W-1:0]  w_sh_cnt;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_sh_out;
  logic             w_last;

  // Flag vector {Z,N,C,V} for a given result and carry/overflow
  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {~|r, r[WIDTH-1], c, v};
  endfunction

  assign w_sum       = {1'b0, seq_if.req_a} + {1'b0, seq_if.req_b};
  assign w_diff      = {1'b0, seq_if.req_a} - {1'b0, seq_if.req_b};
  assign w_is_single = (seq_if.req_op <= OP_SUB);
  assign w_is_shift  = (seq_if.req_op == OP_SHL) || (seq_if.req_op == OP_SHR);
  assign w_sh_cnt    = seq_if.req_b[SH_W-1:0];
  assign w_last      = (cnt_q == CNT_W'(1));

  // Single-cycle logic/arithmetic result computed straight off the request
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (seq_if.req_op)
      OP_AND: w_alu_res = seq_if.req_a & seq_if.req_b;
      OP_OR:  w_alu_res = seq_if.req_a | seq_if.req_b;
      OP_XOR: w_alu_res = seq_if.req_a ^ seq_if.req_b;
      OP_NOT: w_alu_res = ~seq_if.req_a;
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (seq_if.req_a[WIDTH-1] == seq_if.req_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != seq_if.req_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];  // borrow: a < b unsigned
        w_alu_v   = (seq_if.req_a[WIDTH-1] != seq_if.req_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != seq_if.req_a[WIDTH-1]);
      end
      default: w_alu_res = '0;
    endcase
  end

  // One-bit shift step on the working register; carry is the bit shifted out
  always_comb begin
    w_sh_next = '0;
    w_sh_out  = 1'b0;
    if (op_q == OP_SHL) begin
      w_sh_next = {a_q[WIDTH-2:0], 1'b0};
      w_sh_out  = a_q[WIDTH-1];
    end else begin
      w_sh_next = {1'b0, a_q[WIDTH-1:1]};
      w_sh_out  = a_q[0];
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // One shift-add multiply iteration on the double-width accumulator
  always_comb begin
    w_acc_next = acc_q + (b_q[0] ? mcand_q : '0);
    w_mul_hi   = |w_acc_next[2*WIDTH-1:WIDTH];
  end
`endif

  // Next-state, response and flag logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
    b_d      = b_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (seq_if.req_valid) begin
          op_d = seq_if.req_op;
          a_d  = seq_if.req_a;
          if (w_is_single) begin
            result_d = w_alu_res;
            err_d    = 1'b0;
            flags_d  = mk_flags(w_alu_res, w_alu_c, w_alu_v);
            state_d  = ST_DONE;
          end else if (w_is_shift) begin
            if (w_sh_cnt == '0) begin
              // Zero-count shift passes A through with nothing shifted out
              result_d = seq_if.req_a;
              err_d    = 1'b0;
              flags_d  = mk_flags(seq_if.req_a, 1'b0, 1'b0);
              state_d  = ST_DONE;
            end else begin
              cnt_d   = CNT_W'(w_sh_cnt);
              state_d = ST_EXEC;
            end
          end
`ifdef ALU_SEQ_MUL_EN
          else if (seq_if.req_op == OP_MUL) begin
            b_d     = seq_if.req_b;
            mcand_d = {{WIDTH{1'b0}}, seq_if.req_a};
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_EXEC;
          end
`endif
          else begin
            // Illegal opcode: error response, flags untouched
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          acc_d   = w_acc_next;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          if (w_last) begin
            result_d = w_acc_next[WIDTH-1:0];
            err_d    = 1'b0;
            flags_d  = mk_flags(w_acc_next[WIDTH-1:0], w_mul_hi, w_mul_hi);
            state_d  = ST_DONE;
          end
        end else
`endif
        begin
          a_d = w_sh_next;
          if (w_last) begin
            result_d = w_sh_next;
            err_d    = 1'b0;
            flags_d  = mk_flags(w_sh_next, w_sh_out, 1'b0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (seq_if.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // Multiplier operand and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      b_q     <= b_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end
`endif

  assign seq_if.req_ready  = (state_q == ST_IDLE);
  assign seq_if.rsp_valid  = (state_q == ST_DONE);
  assign seq_if.rsp_result = result_q;
  assign seq_if.rsp_err    = err_q;
  assign flags_o           = flags_q;
  assign busy_o            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Directed self-checking bench for alu_op_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(16), .OP_W(4)) bus ();

  alu_op_sequencer #(.WIDTH(16), .OP_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (bus),
    .flags_o(flags),
    .busy_o (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for the response, then complete the handshake.
  // lat = number of clock edges after the accepting edge before rsp_valid is seen.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic err,
                        output logic [3:0] fl, output int lat);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    step();
    bus.req_valid = 1'b0;
    bus.req_op    = 4'hF;
    bus.req_a     = 16'hDEAD;
    bus.req_b     = 16'hBEEF;
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    res = bus.rsp_result;
    err = bus.rsp_err;
    fl  = flags;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    logic        err;
    logic [3:0]  fl;
    int          lat;
    int          seen;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_busy",      32'(busy),          32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_result",    32'(bus.rsp_result), 32'h0);
    check("rst_err",       32'(bus.rsp_err),   32'h0);
    check("rst_flags",     32'(flags),         32'h0);
    rst = 1'b0;
    step();

    // AND F0F0 & 0FF0 = 00F0, flags 0000
    run_op(4'd0, 16'hF0F0, 16'h0FF0, res, err, fl, lat);
    check("and_lat",   32'(lat), 32'd0);
    check("and_res",   32'(res), 32'h00F0);
    check("and_err",   32'(err), 32'h0);
    check("and_flags", 32'(fl),  32'h0);

    // ADD 7FFF + 0001 = 8000, N=1 V=1
    run_op(4'd4, 16'h7FFF, 16'h0001, res, err, fl, lat);
    check("add_lat",   32'(lat), 32'd0);
    check("add_res",   32'(res), 32'h8000);
    check("add_flags", 32'(fl),  32'b0101);

    // SUB 0000 - 0001 = FFFF, N=1 C=1
    run_op(4'd5, 16'h0000, 16'h0001, res, err, fl, lat);
    check("sub_res",   32'(res), 32'hFFFF);
    check("sub_flags", 32'(fl),  32'b0110);

    // SHL C001 by 2 = 0004, last bit out 1
    run_op(4'd6, 16'hC001, 16'h0002, res, err, fl, lat);
    check("shl_lat",   32'(lat), 32'd2);
    check("shl_res",   32'(res), 32'h0004);
    check("shl_flags", 32'(fl),  32'b0010);

    // SHR 1234 by 0 passes through, C=0
    run_op(4'd7, 16'h1234, 16'h0000, res, err, fl, lat);
    check("shr0_lat",   32'(lat), 32'd0);
    check("shr0_res",   32'(res), 32'h1234);
    check("shr0_flags", 32'(fl),  32'b0000);

    // XOR to zero sets Z
    run_op(4'd2, 16'hA5A5, 16'hA5A5, res, err, fl, lat);
    check("xor_res",   32'(res), 32'h0000);
    check("xor_flags", 32'(fl),  32'b1000);

    // MUL 0100 * 0100
    run_op(4'd8, 16'h0100, 16'h0100, res, err, fl, lat);
`ifdef ALU_SEQ_MUL_EN
    check("mul_lat",   32'(lat), 32'd16);
    check("mul_res",   32'(res), 32'h0000);
    check("mul_err",   32'(err), 32'h0);
    check("mul_flags", 32'(fl),  32'b1011);
`else
    check("mul_lat",   32'(lat), 32'd0);
    check("mul_res",   32'(res), 32'h0000);
    check("mul_err",   32'(err), 32'h1);
    check("mul_flags", 32'(fl),  32'b1000);
`endif

    // Backpressure: OR 00FF | FF00 = FFFF held while a new request waits
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd1;
    bus.req_a     = 16'h00FF;
    bus.req_b     = 16'hFF00;
    step();
    bus.req_op    = 4'd0;
    bus.req_a     = 16'h1234;
    bus.req_b     = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid",     32'(bus.rsp_valid),  32'h1);
      check("bp_res",       32'(bus.rsp_result), 32'hFFFF);
      check("bp_flags",     32'(flags),          32'b0100);
      check("bp_req_ready", 32'(bus.req_ready),  32'h0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.req_ready), 32'h1);
    check("bp_idle_valid", 32'(bus.rsp_valid), 32'h0);
    step();
    bus.req_valid = 1'b0;
    check("bp_next_valid", 32'(bus.rsp_valid),  32'h1);
    check("bp_next_res",   32'(bus.rsp_result), 32'h0000);
    check("bp_next_flags", 32'(flags),          32'b1000);
    check("bp_next_err",   32'(bus.rsp_err),    32'h0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset in the middle of SHL by 15
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd6;
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'h000F;
    step();
    bus.req_valid = 1'b0;
    repeat (7) step();
    check("mid_busy",  32'(busy),          32'h1);
    check("mid_valid", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b1;
    step();
    check("abort_valid", 32'(bus.rsp_valid), 32'h0);
    check("abort_flags", 32'(flags),         32'h0);
    check("abort_ready", 32'(bus.req_ready), 32'h1);
    check("abort_busy",  32'(busy),          32'h0);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      step();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);

    // Illegal opcode 12
    run_op(4'd12, 16'h5555, 16'h3333, res, err, fl, lat);
    check("ill_lat",   32'(lat), 32'd0);
    check("ill_err",   32'(err), 32'h1);
    check("ill_res",   32'(res), 32'h0000);
    check("ill_flags", 32'(fl),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
